// File: rtl/regfile_pkg.sv
// Shared sizing helpers for the register file and its busy scoreboard.
package regfile_pkg;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // LSB of read port `port` inside a packed bus of `w`-bit fields
  function automatic int rd_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write-back, claim/flush and busy count.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = calc_aw(DEPTH);
  localparam int CW = calc_cw(DEPTH);

  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic                   we;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wd;
  logic                   claim;
  logic [AW-1:0]          ca;
  logic                   flush;
  logic [CW-1:0]          busy_cnt;

  modport master (
    output rd_addr, we, wa, wd, claim, ca, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, we, wa, wd, claim, ca, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags with an incrementally maintained popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(DEPTH),
  localparam int CW      = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             claim,
  input  logic [AW-1:0]    ca,
  input  logic             flush,
  output logic [DEPTH-1:0] busy,
  output logic [CW-1:0]    busy_cnt
);

  logic             wr_clr;
  logic             clm;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  assign wr_clr = we && !((ZERO_REG != 0) && (wa == '0));
  assign clm    = claim && !((ZERO_REG != 0) && (ca == '0));

  // A same-address claim keeps the bit set, so the write must not decrement
  assign inc = clm && !busy[ca];
  assign dec = wr_clr && busy[wa] && !(clm && (ca == wa));

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt + CW'(inc) - CW'(dec);
    if (wr_clr) busy_nxt[wa] = 1'b0;
    if (clm)    busy_nxt[ca] = 1'b1;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int AW = calc_aw(DEPTH);

  logic [WIDTH-1:0]       rf [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic                   wr_en;
  logic [NREAD*WIDTH-1:0] rd_data_v;
  logic [NREAD-1:0]       rd_busy_v;

  assign wr_en = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[bus.wa] <= bus.wd;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             bsy;

    assign addr = bus.rd_addr[rd_lsb(g, AW) +: AW];

    // Bypassed data reports not-busy since the write-back releases the register
    always_comb begin
      data = rf[addr];
      bsy  = busy[addr];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end else if ((BYPASS != 0) && bus.we && (bus.wa == addr)) begin
        data = bus.wd;
        bsy  = 1'b0;
      end
    end

    assign rd_data_v[rd_lsb(g, WIDTH) +: WIDTH] = data;
    assign rd_busy_v[g]                         = bsy;
  end

  assign bus.rd_data = rd_data_v;
  assign bus.rd_busy = rd_busy_v;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.we),
    .wa       (bus.wa),
    .claim    (bus.claim),
    .ca       (bus.ca),
    .flush    (bus.flush),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: bypassing and non-bypassing instances share one stimulus stream.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = calc_aw(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) bus_b ();
  regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) bus_n ();

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(0), .ZERO_REG(1))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  typedef struct {
    string            name;
    int               inst;   // 0 = bypassing DUT, 1 = non-bypassing DUT
    int               kind;   // 0 = read port, 1 = busy_cnt
    int               port;
    logic [WIDTH-1:0] data;
    logic             busy;
    int               cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_rd(input int inst, input int port, input logic [WIDTH-1:0] d,
                         input logic b, input string n);
    exp_t e;
    e.name = n; e.inst = inst; e.kind = 0; e.port = port;
    e.data = d; e.busy = b; e.cnt = 0;
    q.push_back(e);
  endtask

  task automatic exp_both(input int port, input logic [WIDTH-1:0] d, input logic b,
                          input string n);
    push_rd(0, port, d, b, n);
    push_rd(1, port, d, b, n);
  endtask

  task automatic exp_cnt(input int c, input string n);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.name = n; e.inst = i; e.kind = 1; e.port = 0;
      e.data = '0; e.busy = 1'b0; e.cnt = c;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic w, input int wa_i, input logic [WIDTH-1:0] wd_i,
                       input logic c, input int ca_i, input logic f,
                       input int a0, input int a1);
    bus_b.we = w;  bus_b.wa = AW'(wa_i); bus_b.wd = wd_i;
    bus_b.claim = c; bus_b.ca = AW'(ca_i); bus_b.flush = f;
    bus_b.rd_addr = {AW'(a1), AW'(a0)};
    bus_n.we = w;  bus_n.wa = AW'(wa_i); bus_n.wd = wd_i;
    bus_n.claim = c; bus_n.ca = AW'(ca_i); bus_n.flush = f;
    bus_n.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational/registered and always presented, so
  // every expectation queued for the current cycle is checked mid-cycle.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] act_d;
    logic             act_b;
    int               act_c;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (e.inst == 0) begin
          act_d = bus_b.rd_data[e.port*WIDTH +: WIDTH];
          act_b = bus_b.rd_busy[e.port];
          act_c = int'(bus_b.busy_cnt);
        end else begin
          act_d = bus_n.rd_data[e.port*WIDTH +: WIDTH];
          act_b = bus_n.rd_busy[e.port];
          act_c = int'(bus_n.busy_cnt);
        end
        if (e.kind == 0) begin
          if (act_d !== e.data || act_b !== e.busy) begin
            failures++;
            $display("FAIL %s (inst %0d port %0d): got data=%h busy=%b, want data=%h busy=%b",
                     e.name, e.inst, e.port, act_d, act_b, e.data, e.busy);
          end
        end else if (act_c != e.cnt) begin
          failures++;
          $display("FAIL %s (inst %0d): got busy_cnt=%0d, want %0d",
                   e.name, e.inst, act_c, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    drive(0, 0, '0, 0, 0, 0, 5, 0);
    exp_both(0, '0, 0, "rst_r5");
    exp_both(1, '0, 0, "rst_r0");
    exp_cnt(0, "rst_cnt");
    step();

    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 3, 0);
    exp_both(0, '0, 0, "r3_init");
    step();

    drive(1, 0, 32'h0000_1234, 0, 0, 0, 5, 0);
    exp_both(0, 32'hDEADBEEF, 0, "r5_stored");
    exp_both(1, '0, 0, "r0_write_same_cycle");
    step();

    drive(0, 0, '0, 1, 0, 0, 7, 0);
    exp_both(1, '0, 0, "r0_stored");
    exp_both(0, '0, 0, "r7_old");
    step();

    drive(1, 7, 32'hA5A5A5A5, 0, 0, 0, 5, 7);
    exp_cnt(0, "claim_r0_ignored");
    push_rd(0, 1, 32'hA5A5A5A5, 0, "r7_bypass");
    push_rd(1, 1, '0, 0, "r7_no_bypass");
    step();

    drive(0, 0, '0, 1, 3, 0, 5, 7);
    exp_both(1, 32'hA5A5A5A5, 0, "r7_stored");
    exp_cnt(0, "cnt_claim_latency");
    step();

    drive(0, 0, '0, 0, 0, 0, 3, 7);
    exp_both(0, '0, 1, "r3_claimed");
    exp_cnt(1, "cnt_claim_r3");
    step();

    drive(1, 3, 32'h55, 0, 0, 0, 3, 7);
    push_rd(0, 0, 32'h55, 0, "r3_wb_bypass");
    push_rd(1, 0, '0, 1, "r3_wb_no_bypass");
    exp_cnt(1, "cnt_wb_cycle");
    step();

    drive(1, 9, 32'h77, 1, 9, 0, 3, 0);
    exp_both(0, 32'h55, 0, "r3_released");
    exp_cnt(0, "cnt_released");
    step();

    drive(0, 0, '0, 0, 0, 0, 3, 9);
    exp_both(1, 32'h77, 1, "r9_claim_and_write");
    exp_cnt(1, "cnt_claim_and_write");
    step();

    drive(1, 9, 32'h88, 1, 4, 0, 4, 9);
    exp_both(0, '0, 0, "r4_claim_not_bypassed");
    push_rd(0, 1, 32'h88, 0, "r9_clear_bypass");
    push_rd(1, 1, 32'h77, 1, "r9_clear_no_bypass");
    step();

    drive(0, 0, '0, 0, 0, 0, 4, 9);
    exp_both(0, '0, 1, "r4_claimed");
    exp_both(1, 32'h88, 0, "r9_cleared");
    exp_cnt(1, "cnt_net_zero");
    step();

    drive(0, 0, '0, 1, 1, 0, 1, 2);
    step();
    drive(0, 0, '0, 1, 2, 0, 1, 2);
    exp_both(0, '0, 1, "r1_busy");
    exp_cnt(2, "cnt_two");
    step();
    drive(0, 0, '0, 1, 3, 0, 2, 3);
    exp_both(0, '0, 1, "r2_busy");
    exp_cnt(3, "cnt_three");
    step();

    drive(1, 4, 32'hCC, 1, 6, 1, 6, 3);
    exp_both(1, 32'h55, 1, "r3_busy_pre_flush");
    exp_cnt(4, "cnt_pre_flush");
    step();

    drive(0, 0, '0, 0, 0, 0, 6, 4);
    exp_both(0, '0, 0, "r6_claim_dropped");
    exp_both(1, 32'hCC, 0, "r4_flush_write");
    exp_cnt(0, "cnt_flush");
    step();

    drive(0, 0, '0, 0, 0, 0, 1, 3);
    exp_both(0, '0, 0, "r1_flushed");
    exp_both(1, 32'h55, 0, "r3_flushed");
    step();

    drive(0, 0, '0, 1, 10, 0, 10, 14);
    exp_cnt(0, "cnt_before_r10");
    step();

    drive(1, 10, 32'h99, 1, 14, 0, 10, 14);
    push_rd(0, 0, 32'h99, 0, "r10_wb_bypass");
    push_rd(1, 0, '0, 1, "r10_wb_no_bypass");
    exp_cnt(1, "cnt_r10");
    step();

    rst_n = 1'b0;
    drive(1, 13, 32'h1, 1, 12, 0, 10, 14);
    exp_both(0, 32'h99, 0, "r10_stored");
    exp_both(1, '0, 1, "r14_busy_pre_reset");
    exp_cnt(1, "cnt_pre_reset");
    step();

    rst_n = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 10, 5);
    exp_both(0, '0, 0, "r10_after_reset");
    exp_both(1, '0, 0, "r5_after_reset");
    exp_cnt(0, "cnt_after_reset");
    step();

    drive(0, 0, '0, 0, 0, 0, 14, 13);
    exp_both(0, '0, 0, "r14_claim_dropped");
    exp_both(1, '0, 0, "r13_write_overridden");
    exp_cnt(0, "cnt_claim_overridden");
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
